// File: rtl/rdi_wake_ctrl.sv
// PHY-side RDI wake / clock-gating controller in front of the RDI clock handshake block.
// Answers adapter wakes, runs the clock handshake for PHY wakes, releases queued events, grants gating.
module rdi_wake_ctrl #(
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned HS_TIMEOUT   = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lp_wake_req,
    output logic o_pl_wake_ack,
    input  logic i_phy_clk_ready,
    input  logic i_pl_event_pend,
    output logic o_pl_event_go,
    output logic o_hs_en,
    input  logic i_adapter_is_waked_up,
    output logic o_clk_gate_ok,
    output logic o_hs_timeout
);

    // state    | meaning
    // GATED    | both sides idle, PHY RDI clocks may be gated
    // ACK_WAIT | adapter asked for wake, waiting for PHY clocks before acking
    // HS_WAIT  | PHY wants to talk, clock handshake running until adapter is awake
    // ACTIVE   | both sides awake, events released, idle timer running

    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT) + 1;
    localparam int unsigned HS_W   = $clog2(HS_TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [HS_W-1:0]   HS_LAST   = HS_W'(HS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        GATED    = 2'd0,
        ACK_WAIT = 2'd1,
        HS_WAIT  = 2'd2,
        ACTIVE   = 2'd3
    } state_t;

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [HS_W-1:0]   hs_cnt;
    logic              armed;
    logic              idle;
    logic              release_evt;

    assign idle        = !i_pl_event_pend && !i_lp_wake_req && !o_pl_wake_ack;
    assign release_evt = i_pl_event_pend && armed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= GATED;
            idle_cnt      <= '0;
            hs_cnt        <= '0;
            armed         <= 1'b1;
            o_pl_wake_ack <= 1'b0;
            o_pl_event_go <= 1'b0;
            o_hs_en       <= 1'b0;
            o_clk_gate_ok <= 1'b1;
            o_hs_timeout  <= 1'b0;
        end else begin
            o_pl_event_go <= 1'b0;
            if (!i_pl_event_pend) begin
                armed <= 1'b1;
            end
            if (!i_lp_wake_req) begin
                o_pl_wake_ack <= 1'b0;
            end

            case (state)
                GATED: begin
                    // A requesting adapter already has its clock, so no handshake is needed.
                    if (i_lp_wake_req) begin
                        state         <= ACK_WAIT;
                        o_clk_gate_ok <= 1'b0;
                    end else if (i_pl_event_pend) begin
                        state         <= HS_WAIT;
                        hs_cnt        <= '0;
                        o_hs_en       <= 1'b1;
                        o_clk_gate_ok <= 1'b0;
                    end
                end

                ACK_WAIT: begin
                    if (!i_lp_wake_req) begin
                        state         <= GATED;
                        o_clk_gate_ok <= 1'b1;
                    end else if (i_phy_clk_ready) begin
                        state         <= ACTIVE;
                        idle_cnt      <= '0;
                        o_pl_wake_ack <= 1'b1;
                        if (release_evt) begin
                            o_pl_event_go <= 1'b1;
                            armed         <= 1'b0;
                        end
                    end
                end

                HS_WAIT: begin
                    // Adapter request wins over a concurrent wake so it is always acked.
                    if (i_lp_wake_req) begin
                        state   <= ACK_WAIT;
                        o_hs_en <= 1'b0;
                    end else if (i_adapter_is_waked_up) begin
                        state    <= ACTIVE;
                        idle_cnt <= '0;
                        o_hs_en  <= 1'b0;
                        if (release_evt) begin
                            o_pl_event_go <= 1'b1;
                            armed         <= 1'b0;
                        end
                    end else if (hs_cnt == HS_LAST) begin
                        state         <= GATED;
                        o_hs_en       <= 1'b0;
                        o_hs_timeout  <= 1'b1;
                        o_clk_gate_ok <= 1'b1;
                    end else begin
                        hs_cnt <= hs_cnt + 1'b1;
                    end
                end

                ACTIVE: begin
                    if (release_evt) begin
                        o_pl_event_go <= 1'b1;
                        armed         <= 1'b0;
                    end
                    if (i_lp_wake_req && i_phy_clk_ready && !o_pl_wake_ack) begin
                        o_pl_wake_ack <= 1'b1;
                    end
                    if (!idle) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state         <= GATED;
                        idle_cnt      <= '0;
                        o_clk_gate_ok <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                default: begin
                    state         <= GATED;
                    o_hs_en       <= 1'b0;
                    o_clk_gate_ok <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rdi_wake_ctrl.sv
// Directed testbench for rdi_wake_ctrl with default timeouts (idle 16, handshake 64).
module tb_rdi_wake_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic lp_wake_req;
    logic pl_wake_ack;
    logic phy_clk_ready;
    logic pl_event_pend;
    logic pl_event_go;
    logic hs_en;
    logic adapter_is_waked_up;
    logic clk_gate_ok;
    logic hs_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rdi_wake_ctrl dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_lp_wake_req         (lp_wake_req),
        .o_pl_wake_ack         (pl_wake_ack),
        .i_phy_clk_ready       (phy_clk_ready),
        .i_pl_event_pend       (pl_event_pend),
        .o_pl_event_go         (pl_event_go),
        .o_hs_en               (hs_en),
        .i_adapter_is_waked_up (adapter_is_waked_up),
        .o_clk_gate_ok         (clk_gate_ok),
        .o_hs_timeout          (hs_timeout)
    );

    // Advance one edge; outputs are observed 1 time unit after it, inputs are driven there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gated(input string name, input int expect_n);
        int n;
        n = 0;
        while (clk_gate_ok !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n !== expect_n) begin
            errors++;
            $display("FAIL %s: cycles to gate=%0d expected=%0d", name, n, expect_n);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; lp_wake_req = 0; phy_clk_ready = 0; pl_event_pend = 0; adapter_is_waked_up = 0;
        repeat (3) tick();
        checks++; if (clk_gate_ok !== 1'b1) begin errors++; $display("FAIL reset_gate_ok: got=%b exp=1", clk_gate_ok); end
        checks++; if (pl_wake_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got=%b exp=0", pl_wake_ack); end
        checks++; if (pl_event_go !== 1'b0) begin errors++; $display("FAIL reset_go: got=%b exp=0", pl_event_go); end
        checks++; if (hs_en !== 1'b0) begin errors++; $display("FAIL reset_hs_en: got=%b exp=0", hs_en); end
        checks++; if (hs_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got=%b exp=0", hs_timeout); end
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            tick();
            if (clk_gate_ok !== 1'b1 || hs_en !== 1'b0 || pl_wake_ack !== 1'b0 || pl_event_go !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_stays_gated: bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_phy_wake();
        pl_event_pend = 1'b1;
        tick();
        checks++; if (hs_en !== 1'b1) begin errors++; $display("FAIL phy_hs_en_on: got=%b exp=1", hs_en); end
        checks++; if (clk_gate_ok !== 1'b0) begin errors++; $display("FAIL phy_gate_drop: got=%b exp=0", clk_gate_ok); end
        repeat (8) tick();
        checks++; if (hs_en !== 1'b1 || pl_event_go !== 1'b0) begin errors++; $display("FAIL phy_hs_hold: hs_en=%b go=%b exp 1/0", hs_en, pl_event_go); end
        adapter_is_waked_up = 1'b1;
        tick();
        checks++; if (hs_en !== 1'b0) begin errors++; $display("FAIL phy_hs_en_off: got=%b exp=0", hs_en); end
        checks++; if (pl_event_go !== 1'b1) begin errors++; $display("FAIL phy_go_pulse: got=%b exp=1", pl_event_go); end
        adapter_is_waked_up = 1'b0;
        tick();
        checks++; if (pl_event_go !== 1'b0 || clk_gate_ok !== 1'b0) begin errors++; $display("FAIL phy_go_width: go=%b gate=%b exp 0/0", pl_event_go, clk_gate_ok); end
        tick();
        pl_event_pend = 1'b0;
        wait_gated("phy_idle_gate", 16);
        checks++; if (hs_timeout !== 1'b0) begin errors++; $display("FAIL phy_no_timeout: got=%b exp=0", hs_timeout); end
    endtask

    task automatic test_adapter_wake();
        int hs_seen;
        hs_seen = 0;
        lp_wake_req = 1'b1; phy_clk_ready = 1'b0;
        repeat (5) begin
            tick();
            if (hs_en !== 1'b0) hs_seen++;
        end
        checks++; if (pl_wake_ack !== 1'b0 || clk_gate_ok !== 1'b0) begin errors++; $display("FAIL adp_wait: ack=%b gate=%b exp 0/0", pl_wake_ack, clk_gate_ok); end
        phy_clk_ready = 1'b1;
        tick();
        if (hs_en !== 1'b0) hs_seen++;
        checks++; if (pl_wake_ack !== 1'b1) begin errors++; $display("FAIL adp_ack_on_ready: got=%b exp=1", pl_wake_ack); end
        tick();
        if (hs_en !== 1'b0) hs_seen++;
        lp_wake_req = 1'b0;
        tick();
        if (hs_en !== 1'b0) hs_seen++;
        checks++; if (pl_wake_ack !== 1'b0) begin errors++; $display("FAIL adp_ack_drop: got=%b exp=0", pl_wake_ack); end
        checks++; if (hs_seen !== 0) begin errors++; $display("FAIL adp_no_hs: hs_en_cycles=%0d exp=0", hs_seen); end
        wait_gated("adp_idle_gate", 16);
        // request withdrawn before PHY clocks are up: back to gated with no ack
        phy_clk_ready = 1'b0; lp_wake_req = 1'b1;
        tick();
        tick();
        lp_wake_req = 1'b0;
        tick();
        checks++; if (clk_gate_ok !== 1'b1 || pl_wake_ack !== 1'b0) begin errors++; $display("FAIL adp_abort: gate=%b ack=%b exp 1/0", clk_gate_ok, pl_wake_ack); end
    endtask

    task automatic test_hs_timeout();
        int n;
        pl_event_pend = 1'b1;
        n = 0;
        tick();
        while (hs_en === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        pl_event_pend = 1'b0;
        checks++; if (n !== 64) begin errors++; $display("FAIL hs_en_width: cycles=%0d exp=64", n); end
        checks++; if (hs_timeout !== 1'b1 || clk_gate_ok !== 1'b1) begin errors++; $display("FAIL hs_timeout_set: to=%b gate=%b exp 1/1", hs_timeout, clk_gate_ok); end
        repeat (10) tick();
        checks++; if (hs_timeout !== 1'b1 || hs_en !== 1'b0) begin errors++; $display("FAIL hs_timeout_sticky: to=%b hs_en=%b exp 1/0", hs_timeout, hs_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (hs_timeout !== 1'b0) begin errors++; $display("FAIL hs_timeout_clear: got=%b exp=0", hs_timeout); end
    endtask

    task automatic test_priority();
        int extra;
        pl_event_pend = 1'b1; lp_wake_req = 1'b1; phy_clk_ready = 1'b0;
        tick();
        checks++; if (hs_en !== 1'b0 || clk_gate_ok !== 1'b0 || pl_wake_ack !== 1'b0) begin errors++; $display("FAIL prio_ack_wait: hs_en=%b gate=%b ack=%b exp 0/0/0", hs_en, clk_gate_ok, pl_wake_ack); end
        phy_clk_ready = 1'b1;
        tick();
        checks++; if (pl_wake_ack !== 1'b1 || pl_event_go !== 1'b1) begin errors++; $display("FAIL prio_active: ack=%b go=%b exp 1/1", pl_wake_ack, pl_event_go); end
        extra = 0;
        repeat (5) begin
            tick();
            if (pl_event_go !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL prio_no_repeat: extra_pulses=%0d exp=0", extra); end
        pl_event_pend = 1'b0;
        tick();
        pl_event_pend = 1'b1;
        tick();
        checks++; if (pl_event_go !== 1'b1) begin errors++; $display("FAIL b2b_second_go: got=%b exp=1", pl_event_go); end
        pl_event_pend = 1'b0; lp_wake_req = 1'b0;
        tick();
        wait_gated("prio_idle_gate", 16);
        phy_clk_ready = 1'b0;
    endtask

    task automatic test_hs_preempt();
        pl_event_pend = 1'b1;
        tick();
        lp_wake_req = 1'b1; phy_clk_ready = 1'b1;
        tick();
        checks++; if (hs_en !== 1'b0 || pl_wake_ack !== 1'b0) begin errors++; $display("FAIL preempt_to_ack_wait: hs_en=%b ack=%b exp 0/0", hs_en, pl_wake_ack); end
        tick();
        checks++; if (pl_wake_ack !== 1'b1 || pl_event_go !== 1'b1) begin errors++; $display("FAIL preempt_active: ack=%b go=%b exp 1/1", pl_wake_ack, pl_event_go); end
        pl_event_pend = 1'b0; lp_wake_req = 1'b0; phy_clk_ready = 1'b0;
        tick();
        wait_gated("preempt_idle_gate", 16);
    endtask

    task automatic test_reset_mid();
        pl_event_pend = 1'b1;
        tick();
        checks++; if (hs_en !== 1'b1) begin errors++; $display("FAIL mid_hs_entry: got=%b exp=1", hs_en); end
        rst = 1'b1; adapter_is_waked_up = 1'b1;
        tick();
        checks++; if (hs_en !== 1'b0 || clk_gate_ok !== 1'b1 || pl_event_go !== 1'b0) begin errors++; $display("FAIL mid_hs_reset: hs_en=%b gate=%b go=%b exp 0/1/0", hs_en, clk_gate_ok, pl_event_go); end
        rst = 1'b0; pl_event_pend = 1'b0; adapter_is_waked_up = 1'b0;
        tick();
        lp_wake_req = 1'b1; phy_clk_ready = 1'b1;
        tick();
        tick();
        checks++; if (pl_wake_ack !== 1'b1) begin errors++; $display("FAIL mid_active_ack: got=%b exp=1", pl_wake_ack); end
        rst = 1'b1; pl_event_pend = 1'b1;
        tick();
        checks++; if (pl_wake_ack !== 1'b0 || pl_event_go !== 1'b0 || clk_gate_ok !== 1'b1 || hs_en !== 1'b0) begin errors++; $display("FAIL mid_active_reset: ack=%b go=%b gate=%b hs_en=%b exp 0/0/1/0", pl_wake_ack, pl_event_go, clk_gate_ok, hs_en); end
        rst = 1'b0; pl_event_pend = 1'b0; lp_wake_req = 1'b0; phy_clk_ready = 1'b0;
        tick();
        checks++; if (pl_event_go !== 1'b0 || clk_gate_ok !== 1'b1) begin errors++; $display("FAIL mid_after_reset: go=%b gate=%b exp 0/1", pl_event_go, clk_gate_ok); end
    endtask

    initial begin
        test_reset();
        test_phy_wake();
        test_adapter_wake();
        test_hs_timeout();
        test_priority();
        test_hs_preempt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
